spec_history_reg: RTL and testbench

//  Speculative global branch-history register with checkpoint/restore.

---
 rtl/spec_history_pkg.sv | 16 +
 rtl/spec_history_ckpt_ring.sv | 72 +++++++
 rtl/spec_history_reg.sv | 84 ++++++++
 tb/tb_spec_history_reg.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spec_history_pkg.sv
// Defaults, shared types and the history shift helper for the speculative
// global-history block. HIST_LEN defaults to 16.
package spec_history_pkg;
  localparam int HIST_LEN_DEF   = 16;
  localparam int CKPT_DEPTH_DEF = 16;
  // Widest history the shift helper can carry; callers cast to their width.
  localparam int HIST_MAX       = 64;

  typedef logic [HIST_LEN_DEF-1:0]           hist_t;
  typedef logic [$clog2(CKPT_DEPTH_DEF)-1:0] ckpt_id_t;

  function automatic logic [HIST_MAX-1:0] shift_in(input logic [HIST_MAX-1:0] h,
                                                   input logic                b);
    return {h[HIST_MAX-2:0], b};
  endfunction
endpackage

// File: rtl/spec_history_ckpt_ring.sv
// Circular checkpoint store: one history snapshot per in-flight branch,
// with head/tail/count bookkeeping and younger-entry truncation on mispredict.
module spec_history_ckpt_ring
   import spec_history_pkg::*;
#(
   parameter  int HIST_LEN   = HIST_LEN_DEF,
   parameter  int CKPT_DEPTH = CKPT_DEPTH_DEF,
   localparam int ID_W       = $clog2(CKPT_DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_push,
   input  logic [HIST_LEN-1:0] i_push_hist,
   input  logic                i_trunc,
   input  logic [ID_W-1:0]     i_trunc_id,
   input  logic                i_pop,
   output logic [ID_W-1:0]     o_tail,
   output logic [ID_W:0]       o_count,
   output logic                o_rd_valid,
   output logic [HIST_LEN-1:0] o_rd_hist
);
   logic [HIST_LEN-1:0]   r_ckpt [CKPT_DEPTH];
   logic [CKPT_DEPTH-1:0] r_valid;
   logic [ID_W-1:0]       r_head;
   logic [ID_W-1:0]       r_tail;
   logic [ID_W:0]         r_count;
   logic                  w_pop;
   logic [ID_W-1:0]       w_dist;
   logic [ID_W:0]         w_base;

   assign w_pop  = i_pop && (r_count != '0);
   assign w_dist = i_trunc_id - r_head;

   // Push and truncate never coincide: the top drops a predict during a mispredict.
   always_comb begin
      w_base = r_count + {{ID_W{1'b0}}, i_push};
      if (i_trunc)
         w_base = {1'b0, w_dist} + {{ID_W{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         // Entries whose age offset from head exceeds the resolved id's are younger.
         for (int i = 0; i < CKPT_DEPTH; i++) begin
            if (i_trunc && ((ID_W'(i) - r_head) > w_dist))
               r_valid[i] <= 1'b0;
         end
         if (w_pop)
            r_valid[r_head] <= 1'b0;
         if (i_push)
            r_valid[r_tail] <= 1'b1;
         r_head  <= r_head + {{(ID_W-1){1'b0}}, w_pop};
         r_tail  <= i_trunc ? i_trunc_id + 1'b1 : r_tail + {{(ID_W-1){1'b0}}, i_push};
         r_count <= w_base - {{ID_W{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (i_push)
         r_ckpt[r_tail] <= i_push_hist;
   end

   assign o_tail     = r_tail;
   assign o_count    = r_count;
   assign o_rd_valid = r_valid[i_trunc_id];
   assign o_rd_hist  = r_ckpt[i_trunc_id];
endmodule

// File: rtl/spec_history_reg.sv
// Speculative global branch-history register with per-branch checkpoint/restore.
// Define SPEC_HIST_ARCH_EN to build the retired (architectural) history register.
module spec_history_reg
   import spec_history_pkg::*;
#(
   parameter  int HIST_LEN   = HIST_LEN_DEF,
   parameter  int CKPT_DEPTH = CKPT_DEPTH_DEF,
   localparam int ID_W       = $clog2(CKPT_DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                spec_valid,
   input  logic                spec_taken,
   output logic                spec_ready,
   output logic [ID_W-1:0]     spec_id,
   input  logic                resolve_valid,
   input  logic [ID_W-1:0]     resolve_id,
   input  logic                resolve_mispred,
   input  logic                resolve_taken,
   input  logic                retire_valid,
   input  logic                retire_taken,
   output logic [HIST_LEN-1:0] spec_hist,
   output logic [HIST_LEN-1:0] arch_hist,
   output logic [ID_W:0]       count
);
   logic [HIST_LEN-1:0] r_spec_hist;
   logic                w_rd_valid;
   logic [HIST_LEN-1:0] w_rd_hist;
   logic                w_mispred;
   logic                w_push;

   // A recovering mispredict takes priority and swallows any same-cycle predict.
   assign w_mispred  = resolve_valid && resolve_mispred && w_rd_valid;
   assign spec_ready = count < (ID_W+1)'(CKPT_DEPTH);
   assign w_push     = spec_valid && spec_ready && !w_mispred;

   spec_history_ckpt_ring #(
      .HIST_LEN   (HIST_LEN),
      .CKPT_DEPTH (CKPT_DEPTH)
   ) u_ring (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_push_hist (r_spec_hist),
      .i_trunc     (w_mispred),
      .i_trunc_id  (resolve_id),
      .i_pop       (retire_valid),
      .o_tail      (spec_id),
      .o_count     (count),
      .o_rd_valid  (w_rd_valid),
      .o_rd_hist   (w_rd_hist)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_spec_hist <= '0;
      else if (w_mispred)
         r_spec_hist <= HIST_LEN'(shift_in(HIST_MAX'(w_rd_hist), resolve_taken));
      else if (w_push)
         r_spec_hist <= HIST_LEN'(shift_in(HIST_MAX'(r_spec_hist), spec_taken));
   end

   assign spec_hist = r_spec_hist;

`ifdef SPEC_HIST_ARCH_EN
   logic [HIST_LEN-1:0] r_arch_hist;
   logic                w_retire;

   assign w_retire = retire_valid && (count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_arch_hist <= '0;
      else if (w_retire)
         r_arch_hist <= HIST_LEN'(shift_in(HIST_MAX'(r_arch_hist), retire_taken));
   end

   assign arch_hist = r_arch_hist;
`else
   logic w_unused;
   assign w_unused  = retire_taken;
   assign arch_hist = '0;
`endif
endmodule

// File: tb/tb_spec_history_reg.sv
// Directed bench for spec_history_reg: predict/resolve/retire sequences with
// hand-computed expectations, checked by immediate assertions.
module tb_spec_history_reg;
   import spec_history_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       spec_valid;
   logic       spec_taken;
   logic       spec_ready;
   logic [3:0] spec_id;
   logic       resolve_valid;
   logic [3:0] resolve_id;
   logic       resolve_mispred;
   logic       resolve_taken;
   logic       retire_valid;
   logic       retire_taken;
   hist_t      spec_hist;
   hist_t      arch_hist;
   logic [4:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   spec_history_reg dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .spec_valid      (spec_valid),
      .spec_taken      (spec_taken),
      .spec_ready      (spec_ready),
      .spec_id         (spec_id),
      .resolve_valid   (resolve_valid),
      .resolve_id      (resolve_id),
      .resolve_mispred (resolve_mispred),
      .resolve_taken   (resolve_taken),
      .retire_valid    (retire_valid),
      .retire_taken    (retire_taken),
      .spec_hist       (spec_hist),
      .arch_hist       (arch_hist),
      .count           (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic sv, input logic st,
                       input logic rv, input logic [3:0] rid, input logic rm, input logic rt,
                       input logic tv, input logic tt);
      spec_valid      = sv;
      spec_taken      = st;
      resolve_valid   = rv;
      resolve_id      = rid;
      resolve_mispred = rm;
      resolve_taken   = rt;
      retire_valid    = tv;
      retire_taken    = tt;
      @(posedge clk);
      #1;
      spec_valid      = 1'b0;
      spec_taken      = 1'b0;
      resolve_valid   = 1'b0;
      resolve_id      = 4'd0;
      resolve_mispred = 1'b0;
      resolve_taken   = 1'b0;
      retire_valid    = 1'b0;
      retire_taken    = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] exp_arch;
      rst_n = 1'b0;
      spec_valid = 1'b0; spec_taken = 1'b0;
      resolve_valid = 1'b0; resolve_id = 4'd0; resolve_mispred = 1'b0; resolve_taken = 1'b0;
      retire_valid = 1'b0; retire_taken = 1'b0;

      // Reset state
      #3;
      check("rst_spec_hist", 32'(spec_hist), 0);
      check("rst_arch_hist", 32'(arch_hist), 0);
      check("rst_count", 32'(count), 0);
      check("rst_ready", 32'(spec_ready), 1);
      check("rst_spec_id", 32'(spec_id), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1: predicts T,N,T
      check("t1_id0", 32'(spec_id), 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      check("t1_id1", 32'(spec_id), 1);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("t1_id2", 32'(spec_id), 2);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      check("t1_hist", 32'(spec_hist), 32'h5);
      check("t1_count", 32'(count), 3);

      // 2: fill to depth, overflow predict ignored, retire frees a slot
      do_reset();
      for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
      check("t2_full_count", 32'(count), 16);
      check("t2_full_ready", 32'(spec_ready), 0);
      check("t2_full_hist", 32'(spec_hist), 32'hFFFF);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("t2_ovf_count", 32'(count), 16);
      check("t2_ovf_hist", 32'(spec_hist), 32'hFFFF);
      check("t2_ovf_id", 32'(spec_id), 0);
      step(1, 0, 0, 0, 0, 0, 1, 1);
      check("t2_ret_count", 32'(count), 15);
      check("t2_ret_ready", 32'(spec_ready), 1);
      check("t2_ret_hist", 32'(spec_hist), 32'hFFFF);

      // 3: five taken predicts, mispredict id 2 not-taken
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
      check("t3_pre_hist", 32'(spec_hist), 32'h1F);
      step(0, 0, 1, 4'd2, 1, 0, 0, 0);
      check("t3_hist", 32'(spec_hist), 32'h6);
      check("t3_count", 32'(count), 3);
      check("t3_next_id", 32'(spec_id), 3);
      step(0, 0, 1, 4'd1, 0, 0, 0, 0);
      check("t3_correct_hist", 32'(spec_hist), 32'h6);
      check("t3_correct_count", 32'(count), 3);
      step(0, 0, 1, 4'd4, 1, 1, 0, 0);
      check("t3_stale_hist", 32'(spec_hist), 32'h6);
      check("t3_stale_count", 32'(count), 3);

      // 4: pointer wrap, then mispredict on a wrapped id
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 0, 0, 0, 0, 0, 0);
         step(0, 0, 0, 0, 0, 0, 1, 0);
      end
      check("t4_wrap_count", 32'(count), 0);
      check("t4_wrap_id", 32'(spec_id), 4);
      for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
      check("t4_full_count", 32'(count), 16);
      step(0, 0, 1, 4'd1, 1, 1, 0, 0);
      check("t4_mp_hist", 32'(spec_hist), 32'h3FFF);
      check("t4_mp_count", 32'(count), 14);
      check("t4_mp_id", 32'(spec_id), 2);
      step(0, 0, 1, 4'd3, 1, 0, 0, 0);
      check("t4_stale_hist", 32'(spec_hist), 32'h3FFF);
      check("t4_stale_count", 32'(count), 14);

      // 5: predict + mispredict(head) + retire in one cycle
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 4'd0, 1, 1, 1, 1);
      check("t5_hist", 32'(spec_hist), 32'h1);
      check("t5_count", 32'(count), 0);
      check("t5_id", 32'(spec_id), 1);
      check("t5_ready", 32'(spec_ready), 1);

      // 6: retired history, mispredict leaves it alone, async reset mid-run
`ifdef SPEC_HIST_ARCH_EN
      exp_arch = 32'h6;
`else
      exp_arch = 32'h0;
`endif
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      check("t6_arch", 32'(arch_hist), exp_arch);
      check("t6_count", 32'(count), 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 4'd3, 1, 0, 0, 0);
      check("t6_mp_hist", 32'(spec_hist), 32'hE);
      check("t6_mp_count", 32'(count), 1);
      check("t6_mp_arch", 32'(arch_hist), exp_arch);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_hist", 32'(spec_hist), 0);
      check("t6_rst_arch", 32'(arch_hist), 0);
      check("t6_rst_count", 32'(count), 0);
      check("t6_rst_id", 32'(spec_id), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(0, 0, 1, 4'd0, 1, 1, 0, 0);
      check("t6_post_rst_resolve", 32'(spec_hist), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
